// File: rtl/exu_alu_rglr_pipe.sv
// Regular ALU issue unit with a local datapath, an optional iterative shifter
// and an in-order output buffer that decouples issue from commit backpressure.
module exu_alu_rglr_pipe #(
    parameter int XLEN       = 32,
    parameter int PC_SIZE    = 32,
    parameter int OBUF_DEPTH = 2,
    parameter int ITER_SHIFT = 1,
    parameter int SHIFT_STEP = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_i_valid,
    output logic                alu_i_ready,
    input  logic [3:0]          alu_i_op,
    input  logic                alu_i_op1pc,
    input  logic                alu_i_op2imm,
    input  logic                alu_i_nop,
    input  logic                alu_i_ecall,
    input  logic                alu_i_ebreak,
    input  logic                alu_i_wfi,
    input  logic [XLEN-1:0]     alu_i_rs1,
    input  logic [XLEN-1:0]     alu_i_rs2,
    input  logic [XLEN-1:0]     alu_i_imm,
    input  logic [PC_SIZE-1:0]  alu_i_pc,
    input  logic                alu_i_flush,
    output logic                alu_o_valid,
    input  logic                alu_o_ready,
    output logic [XLEN-1:0]     alu_o_wbck_wdat,
    output logic                alu_o_wbck_err,
    output logic                alu_o_cmt_ecall,
    output logic                alu_o_cmt_ebreak,
    output logic                alu_o_cmt_wfi,
    output logic [3:0]          alu_o_cnt
);

    localparam int LG = $clog2(XLEN);
    localparam int RW = LG + 1;
    localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SRA  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_LUI  = 4'd10;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] op1, op2, res;
    logic [LG-1:0]   shamt;
    logic            is_shift, rsv, iter_go, fire_i;
    logic [XLEN-1:0] i_wdat;
    logic            i_err, i_ec, i_eb, i_wfi;

    logic [XLEN-1:0] sh_val_q, sh_val_nxt;
    logic [RW-1:0]   sh_rem_q, sh_rem_nxt, sh_step;
    logic [1:0]      sh_dir_q;
    logic            sh_err_q, sh_ec_q, sh_eb_q, sh_wfi_q;

    logic            push, pop;
    logic [XLEN-1:0] p_wdat;
    logic            p_err, p_ec, p_eb, p_wfi;

    logic [XLEN-1:0] mem_wdat_q [OBUF_DEPTH];
    logic            mem_err_q  [OBUF_DEPTH];
    logic            mem_ec_q   [OBUF_DEPTH];
    logic            mem_eb_q   [OBUF_DEPTH];
    logic            mem_wfi_q  [OBUF_DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] last_wdat_q;
    logic            last_err_q, last_ec_q, last_eb_q, last_wfi_q;

    assign op1    = alu_i_op1pc ? XLEN'(alu_i_pc) : alu_i_rs1;
    assign op2    = alu_i_op2imm ? alu_i_imm : alu_i_rs2;
    assign shamt  = op2[LG-1:0];
    assign is_shift = (alu_i_op == OP_SLL) | (alu_i_op == OP_SRL)
                    | (alu_i_op == OP_SRA);
    assign rsv    = alu_i_op > OP_LUI;
    assign iter_go = (ITER_SHIFT != 0) & is_shift & ~alu_i_nop
                   & (shamt != '0);
    assign fire_i = alu_i_valid & alu_i_ready;

    always_comb begin
        res = '0;
        case (alu_i_op)
            OP_ADD:  res = op1 + op2;
            OP_SUB:  res = op1 - op2;
            OP_XOR:  res = op1 ^ op2;
            OP_SLL:  res = op1 << shamt;
            OP_SRL:  res = op1 >> shamt;
            OP_SRA:  res = XLEN'($signed(op1) >>> shamt);
            OP_OR:   res = op1 | op2;
            OP_AND:  res = op1 & op2;
            OP_SLT:  res = XLEN'($signed(op1) < $signed(op2));
            OP_SLTU: res = XLEN'(op1 < op2);
            OP_LUI:  res = op2;
            default: res = '0;
        endcase
    end

    // A NOP still occupies a slot but carries no result and no flags.
    assign i_wdat = alu_i_nop ? '0 : res;
    assign i_ec   = ~alu_i_nop & alu_i_ecall;
    assign i_eb   = ~alu_i_nop & alu_i_ebreak;
    assign i_wfi  = ~alu_i_nop & alu_i_wfi;
    assign i_err  = i_ec | i_eb | i_wfi | (~alu_i_nop & rsv);

    assign sh_step = (sh_rem_q < RW'(SHIFT_STEP)) ? sh_rem_q
                                                  : RW'(SHIFT_STEP);
    assign sh_rem_nxt = sh_rem_q - sh_step;

    always_comb begin
        sh_val_nxt = sh_val_q;
        case (sh_dir_q)
            2'd0:    sh_val_nxt = sh_val_q << sh_step;
            2'd1:    sh_val_nxt = sh_val_q >> sh_step;
            default: sh_val_nxt = XLEN'($signed(sh_val_q) >>> sh_step);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (alu_i_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (fire_i && iter_go) state_d = SHIFT;
                SHIFT:   if (sh_rem_nxt == '0) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        alu_i_ready = (state_q == IDLE) & (cnt_q < 4'(OBUF_DEPTH))
                    & ~alu_i_flush;
        push   = 1'b0;
        p_wdat = i_wdat;
        p_err  = i_err;
        p_ec   = i_ec;
        p_eb   = i_eb;
        p_wfi  = i_wfi;
        if (state_q == SHIFT) begin
            push   = (sh_rem_nxt == '0) & ~alu_i_flush;
            p_wdat = sh_val_nxt;
            p_err  = sh_err_q;
            p_ec   = sh_ec_q;
            p_eb   = sh_eb_q;
            p_wfi  = sh_wfi_q;
        end else begin
            push = fire_i & ~iter_go;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_val_q <= '0;
            sh_rem_q <= '0;
            sh_dir_q <= '0;
            sh_err_q <= 1'b0;
            sh_ec_q  <= 1'b0;
            sh_eb_q  <= 1'b0;
            sh_wfi_q <= 1'b0;
        end else if (state_q == IDLE && fire_i && iter_go) begin
            sh_val_q <= op1;
            sh_rem_q <= RW'(shamt);
            sh_dir_q <= (alu_i_op == OP_SLL) ? 2'd0
                      : (alu_i_op == OP_SRL) ? 2'd1 : 2'd2;
            sh_err_q <= i_err;
            sh_ec_q  <= i_ec;
            sh_eb_q  <= i_eb;
            sh_wfi_q <= i_wfi;
        end else if (state_q == SHIFT) begin
            sh_val_q <= sh_val_nxt;
            sh_rem_q <= sh_rem_nxt;
        end
    end

    assign alu_o_valid = cnt_q != 4'd0;
    assign pop   = alu_o_valid & alu_o_ready;
    assign cnt_d = alu_i_flush ? 4'd0 : cnt_q + 4'(push) - 4'(pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            last_wdat_q <= '0;
            last_err_q  <= 1'b0;
            last_ec_q   <= 1'b0;
            last_eb_q   <= 1'b0;
            last_wfi_q  <= 1'b0;
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem_wdat_q[i] <= '0;
                mem_err_q[i]  <= 1'b0;
                mem_ec_q[i]   <= 1'b0;
                mem_eb_q[i]   <= 1'b0;
                mem_wfi_q[i]  <= 1'b0;
            end
        end else begin
            cnt_q <= cnt_d;
            // Popped head is kept so the outputs hold while the buffer is empty.
            if (pop) begin
                last_wdat_q <= mem_wdat_q[rd_q];
                last_err_q  <= mem_err_q[rd_q];
                last_ec_q   <= mem_ec_q[rd_q];
                last_eb_q   <= mem_eb_q[rd_q];
                last_wfi_q  <= mem_wfi_q[rd_q];
            end
            if (alu_i_flush) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) begin
                    mem_wdat_q[wr_q] <= p_wdat;
                    mem_err_q[wr_q]  <= p_err;
                    mem_ec_q[wr_q]   <= p_ec;
                    mem_eb_q[wr_q]   <= p_eb;
                    mem_wfi_q[wr_q]  <= p_wfi;
                    wr_q <= (wr_q == PW'(OBUF_DEPTH - 1)) ? '0 : wr_q + 1'b1;
                end
                if (pop) begin
                    rd_q <= (rd_q == PW'(OBUF_DEPTH - 1)) ? '0 : rd_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        alu_o_cnt = cnt_q;
        if (alu_o_valid) begin
            alu_o_wbck_wdat  = mem_wdat_q[rd_q];
            alu_o_wbck_err   = mem_err_q[rd_q];
            alu_o_cmt_ecall  = mem_ec_q[rd_q];
            alu_o_cmt_ebreak = mem_eb_q[rd_q];
            alu_o_cmt_wfi    = mem_wfi_q[rd_q];
        end else begin
            alu_o_wbck_wdat  = last_wdat_q;
            alu_o_wbck_err   = last_err_q;
            alu_o_cmt_ecall  = last_ec_q;
            alu_o_cmt_ebreak = last_eb_q;
            alu_o_cmt_wfi    = last_wfi_q;
        end
    end

endmodule

// File: doc/exu_alu_rglr_pipe.md
Name: exu_alu_rglr_pipe

Overview:
Parametrised successor to the regular ALU issue unit. It has its own local datapath and registers every result into an output buffer of OBUF_DEPTH entries. Shifts can optionally be iterative, with a multi-cycle shift FSM. A flush discards all in-flight work. The block sits between dispatch and the commit/writeback stage of the EXU, and decouples ALU issue from commit backpressure.

Parameters:
XLEN, 32, operand/result width (32 or 64)
PC_SIZE, 32, PC width; the PC is zero-extended to XLEN when used as op1
OBUF_DEPTH, 2, output buffer entries, power of 2, range 1..8
ITER_SHIFT, 1, 1 = shifts run iteratively; 0 = shifts complete in a single cycle
SHIFT_STEP, 8, bits shifted per iteration cycle; power of 2, no larger than XLEN

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
alu_i_valid  in  1  issue request
alu_i_ready  out  1  issue accept
alu_i_op  in  4  0 ADD, 1 SUB, 2 XOR, 3 SLL, 4 SRL, 5 SRA, 6 OR, 7 AND, 8 SLT, 9 SLTU, 10 LUI, 11-15 reserved
alu_i_op1pc  in  1  op1 = pc, else rs1
alu_i_op2imm  in  1  op2 = imm, else rs2
alu_i_nop  in  1  NOP: result forced to 0
alu_i_ecall / alu_i_ebreak / alu_i_wfi  in  1 each  system-op flags
alu_i_rs1, alu_i_rs2, alu_i_imm  in  XLEN each  operands
alu_i_pc  in  PC_SIZE  instruction PC
alu_i_flush  in  1  discard buffer contents and any in-progress shift
alu_o_valid  out  1  buffer head valid
alu_o_ready  in  1  commit accepts the head
alu_o_wbck_wdat  out  XLEN  head result
alu_o_wbck_err  out  1  head error
alu_o_cmt_ecall / alu_o_cmt_ebreak / alu_o_cmt_wfi  out  1 each  head flags
alu_o_cnt  out  4  buffer occupancy

Behaviour:
- Reset (rst_n low at a clk edge): buffer empty, FSM in IDLE, alu_o_valid=0, all alu_o_* data/flag outputs 0, alu_o_cnt=0. A reset during a shift aborts the shift and produces no entry.
- Handshakes: issue completes when alu_i_valid & alu_i_ready; output completes when alu_o_valid & alu_o_ready.
- alu_i_ready = (state==IDLE) & (cnt<OBUF_DEPTH) & ~alu_i_flush. A pop in the same cycle does NOT raise ready (no bypass).
- Operands: op1 = op1pc ? zero-extended pc : rs1; op2 = op2imm ? imm : rs2.
- Arithmetic: all results are XLEN bits, and ADD/SUB wrap modulo 2^XLEN. SLT is signed and SLTU is unsigned; both give 0 or 1. LUI result = op2.
- Shift amount = op2[log2(XLEN)-1:0]. SRA fills with op1's sign bit.
- NOP: result 0; the entry is still pushed with all flags 0.
- Reserved op: result 0, err=1.
- Error rule: err = ecall | ebreak | wfi | reserved. wdat is still written on error.
- Non-shift ops, shifts with ITER_SHIFT=0, and shifts with amount 0 are pushed on the accept edge. alu_o_valid is therefore visible in the next cycle (latency 1).
- Iterative shift (ITER_SHIFT=1, amount n>0): on accept, the FSM goes IDLE->SHIFT and latches value, remaining, direction and flags.
  - Each SHIFT cycle shifts the value by min(remaining, SHIFT_STEP).
  - The edge that brings remaining to 0 pushes the entry and returns the FSM to IDLE.
  - Latency = ceil(n/SHIFT_STEP) cycles from accept to alu_o_valid.
  - The push is always accepted: space was reserved at accept, and nothing else can push while in SHIFT.
- Buffer: in-order FIFO; the head drives alu_o_*.
  - Push and pop in the same cycle: cnt unchanged, order preserved.
  - Full: ready=0.
  - Empty: alu_o_valid=0 and data outputs hold their last value.
  - Pointers wrap modulo OBUF_DEPTH.
- Flush (sampled at the edge): cnt becomes 0, the FSM returns to IDLE, and the shift in progress is dropped. No issue is accepted that cycle. A pop in the same cycle counts as completed; its data is still discarded.
- alu_o_valid depends only on registered state. There is no combinational path from alu_i_* to alu_o_*.

Test Plan:
- Reset then ADD rs1=0xFFFFFFFF, rs2=2, op2imm=0 -> one cycle later alu_o_valid=1, wdat=0x00000001, err=0, cnt=1.
- SLT rs1=0x80000000, rs2=1 -> wdat=1. SLTU with the same operands -> wdat=0. SRA 0x80000000 by 4 (ITER_SHIFT=1, STEP=8) -> wdat=0xF8000000, latency 1.
- SLL 0x1 by 31 with STEP=8 -> alu_i_ready=0 for 4 cycles, valid 4 cycles after accept, wdat=0x80000000.
- Hold alu_o_ready=0 with OBUF_DEPTH=2 and issue 3 ADDs -> only 2 accepted, cnt=2, ready=0. Release -> FIFO order preserved, third op accepted.
- ecall with rs1=5, imm=0, op2imm=1 -> wdat=5, err=1, cmt_ecall=1. Op 12 -> wdat=0, err=1.
- Assert flush mid-shift with 1 entry buffered -> next cycle cnt=0, valid=0, FSM IDLE, ready=1. Assert rst_n=0 mid-shift -> same empty state and no entry is produced.
